// File: rtl/program_loader_pkg.sv
// Shared types and constants for the byte-stream program loader.
// PROGRAM_LOADER_CHECKSUM_EN (see program_loader.sv) adds the CHECK state to the flow.
package program_loader_pkg;

  typedef enum logic [2:0] {
    COUNT = 3'd0,
    DATA  = 3'd1,
    FLUSH = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4,
    ERROR = 3'd5
  } state_t;

  localparam int          BYTES_PER_WORD       = 4;
  localparam logic [31:0] DEFAULT_BASE_ADDRESS = 32'h0040_0000;

  // Byte address of word idx; wraps modulo 2^32.
  function automatic logic [31:0] word_address(input logic [31:0] base,
                                               input logic [31:0] idx);
    return base + idx * 32'(BYTES_PER_WORD);
  endfunction

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and program-memory write port of the loader.
// A byte moves on a rising edge where byte_valid && byte_ready; byte_ready does not depend on byte_valid.
interface program_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic        mem_write_en;
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;

  modport master (
    output byte_in, byte_valid,
    input  byte_ready, mem_write_en, mem_address, mem_write_data
  );

  modport slave (
    input  byte_in, byte_valid,
    output byte_ready, mem_write_en, mem_address, mem_write_data
  );
endinterface

// File: rtl/program_loader_word_assembler.sv
// 8->32 big-endian word assembler: first byte of a word ends up in [31:24].
// o_word/o_word_ready are valid in the cycle the 4th byte is presented.
module word_assembler
  import program_loader_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_byte_en,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_ready
);

  logic [23:0] r_shift;
  logic [1:0]  r_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift <= '0;
      r_count <= '0;
    end else if (i_byte_en) begin
      r_shift <= {r_shift[15:0], i_byte};
      r_count <= r_count + 2'd1;
    end
  end

  assign o_word       = {r_shift, i_byte};
  assign o_word_ready = i_byte_en && (r_count == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/program_loader.sv
// Program loader top: word-count header, sequential memory writes, CPU reset hold.
// Define PROGRAM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int          MEMORY_DEPTH = 32,
  parameter logic [31:0] BASE_ADDRESS = DEFAULT_BASE_ADDRESS
) (
  input  logic                            clk,
  input  logic                            reset,
  program_loader_if.slave                 bus,
  input  logic                            reload,
  output logic                            cpu_reset,
  output logic                            load_done,
  output logic                            load_error,
  output logic [$clog2(MEMORY_DEPTH):0]   words_loaded,
  output state_t                          o_dbg_state
);

  localparam int WL_W = $clog2(MEMORY_DEPTH) + 1;

`ifdef PROGRAM_LOADER_CHECKSUM_EN
  localparam state_t END_STATE = CHECK;
  logic [7:0] r_xor;
`else
  localparam state_t END_STATE = FLUSH;
`endif

  state_t            r_state;
  logic [WL_W-1:0]   r_words;
  logic [WL_W-1:0]   r_n;
  logic              r_we;
  logic [31:0]       r_addr;
  logic [31:0]       r_data;
  logic              w_accept;
  logic              w_stream_byte;
  logic [31:0]       w_word;
  logic              w_word_ready;
  logic              w_oversize;

  assign bus.byte_ready = !reset && (r_state == COUNT || r_state == DATA || r_state == CHECK);
  assign w_accept       = bus.byte_valid && bus.byte_ready;
  assign w_stream_byte  = w_accept && (r_state == COUNT || r_state == DATA);
  assign w_oversize     = w_word > 32'(MEMORY_DEPTH);

  word_assembler u_word_assembler (
    .clk          (clk),
    .reset        (reset),
    .i_byte_en    (w_stream_byte),
    .i_byte       (bus.byte_in),
    .o_word       (w_word),
    .o_word_ready (w_word_ready)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= COUNT;
      r_words <= '0;
      r_n     <= '0;
      r_we    <= 1'b0;
      r_addr  <= BASE_ADDRESS;
      r_data  <= '0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      r_xor   <= '0;
`endif
    end else begin
      r_we <= 1'b0;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      if (w_stream_byte) r_xor <= r_xor ^ bus.byte_in;
`endif
      case (r_state)
        COUNT: if (w_word_ready) begin
          r_n <= w_word[WL_W-1:0];
          if (w_word == 32'd0)  r_state <= END_STATE;
          else if (w_oversize)  r_state <= ERROR;
          else                  r_state <= DATA;
        end
        DATA: if (w_word_ready) begin
          r_we    <= 1'b1;
          r_addr  <= word_address(BASE_ADDRESS, 32'(r_words));
          r_data  <= w_word;
          r_words <= r_words + WL_W'(1);
          if ((r_words + WL_W'(1)) == r_n) r_state <= END_STATE;
        end
        FLUSH: r_state <= DONE;
        CHECK: begin
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          if (w_accept) r_state <= (bus.byte_in == r_xor) ? DONE : ERROR;
`else
          r_state <= ERROR;
`endif
        end
        DONE, ERROR: if (reload) begin
          // Memory contents stay; only the loader's own bookkeeping restarts.
          r_state <= COUNT;
          r_words <= '0;
          r_n     <= '0;
          r_addr  <= BASE_ADDRESS;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
          r_xor   <= '0;
`endif
        end
        default: r_state <= COUNT;
      endcase
    end
  end

  assign bus.mem_write_en   = r_we;
  assign bus.mem_address    = r_addr;
  assign bus.mem_write_data = r_data;
  assign cpu_reset          = (r_state != DONE);
  assign load_done          = (r_state == DONE);
  assign load_error         = (r_state == ERROR);
  assign words_loaded       = r_words;
  assign o_dbg_state        = r_state;

endmodule
